addsub_result_sink: RTL

- Receiving end of the adder/subtractor pipeline's output stream.
- That pipeline has no backpressure: it emits result, carry/borrow and a valid pulse a fixed number of cycles after launch.
- This block buffers those results in a FIFO and presents them downstream with a valid/ready handshake.
- It also runs a credit counter that the issuing logic must check before launching an operation, so the FIFO can never be overrun, whatever the pipeline latency.

---
 rtl/addsub_result_sink.sv | 118 +++++++++++
 1 files changed

// File: rtl/addsub_result_sink.sv
// Result sink for the add/sub pipeline: a FIFO with a valid/ready head, plus issue credits so it can never overflow.
// Define ADDSUB_SINK_BYPASS_EN to forward the input straight to the output when the FIFO is empty and ready is high.
module addsub_result_sink #(
    parameter  int DATAWIDTH = 8,
    parameter  int DEPTH     = 4,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue,
    output logic                 credit_ok,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_result,
    input  logic                 in_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_result,
    output logic                 out_carry,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow_err,
    output logic                 credit_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATAWIDTH:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_credits;
    logic                r_overflow_err;
    logic                r_credit_err;

    logic w_bypass;
    logic w_pop;
    logic w_pop_fifo;
    logic w_push;
    logic w_drop;
    logic w_cred_inc;
    logic w_cred_dec;
    logic w_full;
    logic w_empty;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

`ifdef ADDSUB_SINK_BYPASS_EN
    // Empty FIFO with a ready consumer: the input is consumed without touching storage.
    assign w_bypass                = w_empty && in_valid && out_ready;
    assign out_valid               = !w_empty || w_bypass;
    assign {out_carry, out_result} = w_bypass ? {in_carry, in_result} : r_mem[r_rd_ptr];
`else
    assign w_bypass                = 1'b0;
    assign out_valid               = !w_empty;
    assign {out_carry, out_result} = r_mem[r_rd_ptr];
`endif

    assign w_pop      = out_valid && out_ready;
    assign w_pop_fifo = w_pop && !w_bypass;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = in_valid && !w_bypass && (!w_full || w_pop_fifo);
    assign w_drop     = in_valid && !w_bypass && w_full && !w_pop_fifo;
    assign w_cred_dec = issue && (r_credits != '0);
    assign w_cred_inc = w_pop && (r_credits != FULL_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {in_carry, in_result};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop_fifo})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= FULL_CNT;
        end else begin
            case ({w_cred_inc, w_cred_dec})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow_err <= 1'b0;
            r_credit_err   <= 1'b0;
        end else begin
            if (w_drop)                         r_overflow_err <= 1'b1;
            if (issue && (r_credits == '0))     r_credit_err   <= 1'b1;
        end
    end

    assign credit_ok    = (r_credits != '0);
    assign count        = r_count;
    assign overflow_err = r_overflow_err;
    assign credit_err   = r_credit_err;
endmodule
